// File: rtl/jtkcpu_useq_if.sv
// jtkcpu_useq_if: control and status bundle between the JTKCPU decoder side
// and the microcode sequencer.
// master: decoder/ucode side, drives the controls and reads addr/intvec/sp/err.
// slave : sequencer side, reads the controls and drives addr/intvec/sp/err.
interface jtkcpu_useq_if #(
   parameter int AW   = 10,
   parameter int CW   = 6,
   parameter int NINT = 3,
   parameter int SPW  = 3
);
   logic            cen;
   logic            stall;
   logic            halt;
   logic [CW-1:0]   cat_in;
   logic            ni;
   logic            skip;
   logic            skip_cond;
   logic            jmp;
   logic [CW-1:0]   jmp_cat;
   logic            call;
   logic [CW-1:0]   call_cat;
   logic [CW-1:0]   ret_cat;
   logic            ret;
   logic [NINT-1:0] int_req;
   logic [NINT-1:0] int_mask;
   logic [AW-1:0]   addr;
   logic [NINT:0]   intvec;
   logic [SPW-1:0]  sp;
   logic            err;

   modport master (
      output cen, stall, halt, cat_in, ni, skip, skip_cond, jmp, jmp_cat,
             call, call_cat, ret_cat, ret, int_req, int_mask,
      input  addr, intvec, sp, err
   );

   modport slave (
      input  cen, stall, halt, cat_in, ni, skip, skip_cond, jmp, jmp_cat,
             call, call_cat, ret_cat, ret, int_req, int_mask,
      output addr, intvec, sp, err
   );
endinterface

// File: rtl/jtkcpu_useq.sv
// jtkcpu_useq: microcode address sequencer with a call/return stack and
// prioritised, maskable interrupt entry at instruction boundaries.
// Ports: clk, rst (sync, active-high); bus (jtkcpu_useq_if.slave) carries
// cen/stall/halt, the ni/skip/jmp/call/ret controls, interrupt request/mask,
// and returns the registered addr, the routine source intvec, sp and err.
// Optional feature macro: JTKCPU_USEQ_CHK_EN enables stack error detection
// (sticky err, frozen sequencer); without it the stack pointer wraps.
module jtkcpu_useq #(
   parameter int AW        = 10,
   parameter int CW        = 6,
   parameter int DEPTH     = 4,
   parameter int NINT      = 3,
   parameter int RESET_CAT = 0,
   parameter int INT_BASE  = 1
) (
   input logic          clk,
   input logic          rst,
   jtkcpu_useq_if.slave bus
);
   localparam int OW  = AW - CW;            // offset bits inside a routine
   localparam int PW  = $clog2(DEPTH);      // stack index width
   localparam int SPW = PW + 1;             // occupancy can reach DEPTH

   logic [CW-1:0]   stack [0:DEPTH-1];
   logic [AW-1:0]   addr_q, addr_nx;
   logic [SPW-1:0]  sp_q, sp_nx;
   logic [NINT:0]   intvec_q, intvec_nx;
   logic            err_q;
   logic            push;
   logic [PW-1:0]   wr_idx, rd_idx;
   logic [NINT-1:0] pend;
   logic            int_hit;
   logic [CW-1:0]   int_cat;
   logic [NINT:0]   int_vec;
   logic            run;

`ifdef JTKCPU_USEQ_CHK_EN
   logic err_nx;
`endif

   assign wr_idx = sp_q[PW-1:0];
   assign rd_idx = sp_q[PW-1:0] - 1'b1;     // wraps to DEPTH-1 on underflow
   assign pend   = bus.int_req & ~bus.int_mask;
   // err freezes the sequencer exactly like halt does
   assign run    = bus.cen & ~bus.halt & ~err_q;

   // Lowest pending index wins: scan downwards so the last hit is the lowest
   always_comb begin
      int_hit = 1'b0;
      int_cat = '0;
      int_vec = '0;
      for (int i = NINT - 1; i >= 0; i--) begin
         if (pend[i]) begin
            int_hit    = 1'b1;
            int_cat    = CW'(INT_BASE + i);
            int_vec    = '0;
            int_vec[i] = 1'b1;
         end
      end
   end

   always_comb begin
      addr_nx   = addr_q;
      sp_nx     = sp_q;
      intvec_nx = intvec_q;
      push      = 1'b0;
`ifdef JTKCPU_USEQ_CHK_EN
      err_nx    = err_q;
`endif
      if (bus.ret) begin
`ifdef JTKCPU_USEQ_CHK_EN
         if (sp_q == '0) begin
            err_nx = 1'b1;
         end else begin
            sp_nx   = sp_q - 1'b1;
            addr_nx = {stack[rd_idx], {OW{1'b0}}};
         end
`else
         sp_nx   = {1'b0, rd_idx};
         addr_nx = {stack[rd_idx], {OW{1'b0}}};
`endif
      end else if (bus.jmp) begin
         addr_nx = {bus.jmp_cat, {OW{1'b0}}};
      end else if (bus.call) begin
`ifdef JTKCPU_USEQ_CHK_EN
         if (sp_q == SPW'(DEPTH)) begin
            err_nx = 1'b1;
         end else begin
            push    = 1'b1;
            sp_nx   = sp_q + 1'b1;
            addr_nx = {bus.call_cat, {OW{1'b0}}};
         end
`else
         push    = 1'b1;
         sp_nx   = {1'b0, wr_idx + 1'b1};   // overflow overwrites the oldest slot
         addr_nx = {bus.call_cat, {OW{1'b0}}};
`endif
      end else if (bus.ni) begin
         // a new instruction starts with an empty stack
         sp_nx = '0;
         if (int_hit) begin
            addr_nx   = {int_cat, {OW{1'b0}}};
            intvec_nx = int_vec;
         end else begin
            addr_nx   = {bus.cat_in, {OW{1'b0}}};
            intvec_nx = '0;
         end
      end else if (!bus.stall) begin
         addr_nx = addr_q + ((bus.skip & bus.skip_cond) ? AW'(2) : AW'(1));
      end
   end

   // Reset is applied regardless of cen/halt so the stack is discarded at once
   always_ff @(posedge clk) begin
      if (rst) begin
         addr_q   <= {CW'(RESET_CAT), {OW{1'b0}}};
         sp_q     <= '0;
         intvec_q <= {1'b1, {NINT{1'b0}}};
      end else if (run) begin
         addr_q   <= addr_nx;
         sp_q     <= sp_nx;
         intvec_q <= intvec_nx;
      end
   end

`ifdef JTKCPU_USEQ_CHK_EN
   always_ff @(posedge clk) begin
      if (rst)      err_q <= 1'b0;
      else if (run) err_q <= err_nx;
   end
`else
   assign err_q = 1'b0;
`endif

   // Stack contents are not reset
   always_ff @(posedge clk) begin
      if (!rst && run && push) stack[wr_idx] <= bus.ret_cat;
   end

   assign bus.addr   = addr_q;
   assign bus.sp     = sp_q;
   assign bus.intvec = intvec_q;
   assign bus.err    = err_q;
endmodule

// File: tb/tb_jtkcpu_useq.sv
// Directed bench for jtkcpu_useq. CW=4 is used so each routine spans 64 rows
// (addr = cat*0x40), which keeps the hand-written addresses short.
module tb_jtkcpu_useq;
   localparam int AW = 10, CW = 4, DEPTH = 4, NINT = 3, SPW = 3;

   logic clk = 1'b0;
   logic rst;
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   jtkcpu_useq_if #(.AW(AW), .CW(CW), .NINT(NINT), .SPW(SPW)) bus ();

   jtkcpu_useq #(
      .AW(AW), .CW(CW), .DEPTH(DEPTH), .NINT(NINT), .RESET_CAT(0), .INT_BASE(1)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.stall = 0; bus.halt = 0; bus.cat_in = '0; bus.ni = 0;
      bus.skip = 0; bus.skip_cond = 0; bus.jmp = 0; bus.jmp_cat = '0;
      bus.call = 0; bus.call_cat = '0; bus.ret_cat = '0; bus.ret = 0;
      bus.int_req = '0; bus.int_mask = '0;
   endtask

   initial begin
      idle();
      bus.cen = 1;
      rst = 1;
      tick(); tick();
      chk("rst_addr",   32'(bus.addr),   32'h000);
      chk("rst_intvec", 32'(bus.intvec), 32'b1000);
      chk("rst_sp",     32'(bus.sp),     0);
      chk("rst_err",    32'(bus.err),    0);
      rst = 0;

      // sequential advance
      tick(); chk("seq1", 32'(bus.addr), 1);
      tick(); chk("seq2", 32'(bus.addr), 2);
      tick(); chk("seq3", 32'(bus.addr), 3);
      chk("seq_intvec", 32'(bus.intvec), 32'b1000);
      bus.stall = 1;
      tick(); chk("stall_a", 32'(bus.addr), 3);
      tick(); chk("stall_b", 32'(bus.addr), 3);
      bus.stall = 0; bus.cen = 0;
      tick(); chk("cen0", 32'(bus.addr), 3);
      bus.cen = 1;
      tick(); tick(); chk("seq5", 32'(bus.addr), 5);

      // skip
      bus.skip = 1; bus.skip_cond = 1; bus.stall = 1;
      tick(); chk("skip_stall", 32'(bus.addr), 5);
      bus.stall = 0;
      tick(); chk("skip_yes", 32'(bus.addr), 7);
      bus.skip_cond = 0;
      tick(); chk("skip_nocond", 32'(bus.addr), 8);
      bus.skip = 0;

      // halt freezes, jmp resumes afterwards
      bus.halt = 1; bus.jmp = 1; bus.jmp_cat = 2;
      tick(); chk("halt", 32'(bus.addr), 8);
      bus.halt = 0;
      tick(); chk("jmp", 32'(bus.addr), 32'h080);
      bus.jmp = 0;

      // nested calls and returns
      bus.call = 1; bus.call_cat = 9; bus.ret_cat = 12;
      tick(); chk("call1_addr", 32'(bus.addr), 32'h240); chk("call1_sp", 32'(bus.sp), 1);
      bus.call_cat = 10; bus.ret_cat = 13;
      tick(); chk("call2_addr", 32'(bus.addr), 32'h280); chk("call2_sp", 32'(bus.sp), 2);
      bus.call = 0; bus.ret = 1;
      tick(); chk("ret1_addr", 32'(bus.addr), 32'h340); chk("ret1_sp", 32'(bus.sp), 1);
      tick(); chk("ret2_addr", 32'(bus.addr), 32'h300); chk("ret2_sp", 32'(bus.sp), 0);
      bus.ret = 0;

      // interrupt arbitration on ni
      bus.ni = 1; bus.int_req = 3'b110; bus.int_mask = 3'b010;
      tick(); chk("ni_int_addr", 32'(bus.addr), 32'h0C0); chk("ni_int_vec", 32'(bus.intvec), 32'b0100);
      bus.int_req = 0; bus.int_mask = 0; bus.cat_in = 7;
      tick(); chk("ni_op_addr", 32'(bus.addr), 32'h1C0); chk("ni_op_vec", 32'(bus.intvec), 0);
      bus.ni = 0;
      tick(); chk("vec_hold", 32'(bus.intvec), 0); chk("after_ni", 32'(bus.addr), 32'h1C1);
      bus.ni = 1; bus.int_req = 3'b011;
      tick(); chk("ni_ch0_addr", 32'(bus.addr), 32'h040); chk("ni_ch0_vec", 32'(bus.intvec), 32'b0001);
      bus.ni = 0; bus.int_req = 0;

      // ret beats jmp and ni in the same cycle
      bus.call = 1; bus.call_cat = 6; bus.ret_cat = 5;
      tick(); chk("pcall_addr", 32'(bus.addr), 32'h180);
      bus.call = 0; bus.ret = 1; bus.jmp = 1; bus.jmp_cat = 2;
      bus.ni = 1; bus.int_req = 3'b010; bus.cat_in = 7;
      tick();
      chk("prio_addr", 32'(bus.addr), 32'h140); chk("prio_sp", 32'(bus.sp), 0);
      chk("prio_vec", 32'(bus.intvec), 32'b0001);
      bus.ret = 0; bus.ni = 0; bus.int_req = 0;

      // jmp beats call; the ignored call must not push
      bus.call = 1; bus.call_cat = 9; bus.ret_cat = 3;
      tick(); chk("jc_addr", 32'(bus.addr), 32'h080); chk("jc_sp", 32'(bus.sp), 0);
      bus.jmp = 0;

      // ni empties the stack
      tick(); chk("nc_sp", 32'(bus.sp), 1);
      bus.call = 0; bus.ni = 1; bus.cat_in = 3;
      tick(); chk("ni_clr_addr", 32'(bus.addr), 32'h0C0); chk("ni_clr_sp", 32'(bus.sp), 0);
      bus.ni = 0;

      // five consecutive calls into a 4-deep stack
      bus.call = 1;
      for (int k = 1; k <= 5; k++) begin
         bus.call_cat = CW'(k); bus.ret_cat = CW'(8 + k);
         tick();
      end
      bus.call = 0;
`ifdef JTKCPU_USEQ_CHK_EN
      chk("ovf_err",  32'(bus.err),  1);
      chk("ovf_addr", 32'(bus.addr), 32'h100);
      chk("ovf_sp",   32'(bus.sp),   4);
      bus.jmp = 1; bus.jmp_cat = 2;
      tick(); chk("err_frozen", 32'(bus.addr), 32'h100);
      bus.jmp = 0;
      rst = 1;
      tick(); chk("err_rst", 32'(bus.err), 0);
      rst = 0; bus.ret = 1;
      tick(); chk("unf_err", 32'(bus.err), 1); chk("unf_addr", 32'(bus.addr), 32'h000);
      chk("unf_sp", 32'(bus.sp), 0);
      bus.ret = 0;
`else
      chk("ovf_err",  32'(bus.err),  0);
      chk("ovf_addr", 32'(bus.addr), 32'h140);
      chk("ovf_sp",   32'(bus.sp),   1);
      bus.ret = 1;
      // slot 0 was overwritten by the fifth call (ret_cat 13)
      tick(); chk("wrap_ret_addr", 32'(bus.addr), 32'h340); chk("wrap_ret_sp", 32'(bus.sp), 0);
      // underflow reads slot 3, written by the fourth call (ret_cat 12)
      tick(); chk("unf_addr", 32'(bus.addr), 32'h300); chk("unf_sp", 32'(bus.sp), 3);
      chk("unf_err", 32'(bus.err), 0);
      bus.ret = 0;
`endif

      // reset discards the stack mid-call
      bus.call = 1; bus.call_cat = 5; bus.ret_cat = 1;
      tick();
      bus.call = 0; rst = 1; bus.halt = 1;
      tick();
      chk("rst_mid_addr", 32'(bus.addr), 0); chk("rst_mid_sp", 32'(bus.sp), 0);
      chk("rst_mid_vec", 32'(bus.intvec), 32'b1000);
      rst = 0; bus.halt = 0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/jtkcpu_useq.md
# jtkcpu_useq

Parametrised microcode sequencer for the JTKCPU core. It generates the ucode ROM address from a routine category and an offset within that routine. It supports nested ucode subroutine calls through a return stack of configurable depth, and arbitrates a configurable number of prioritised, maskable interrupt channels at instruction boundaries. It sits between the opcode-category decoder and the ucode ROM, and replaces the single-level "after index" return with a general call/return mechanism.

## Interface
Parameters:
- `AW`, 10, ucode address width
- `CW`, 6, category width; each routine owns 2^(AW-CW) rows
- `DEPTH`, 4, return-stack entries (power of two, ≥2)
- `NINT`, 3, interrupt channels; channel 0 has the highest priority
- `RESET_CAT`, 0, category entered after reset
- `INT_BASE`, 1, category of channel 0; channel i uses `INT_BASE+i`

Ports:
- `clk` in 1: clock
- `rst` in 1: reset, synchronous, active-high
- `cen` in 1: clock enable; all state changes require `cen=1`
- `stall` in 1: memory or index unit busy; blocks sequential advance only
- `halt` in 1: bus error; freezes all state while high
- `cat_in` in CW: category of the opcode currently fetched
- `ni` in 1: ucode "next instruction" strobe
- `skip` in 1: request to advance by 2 instead of 1
- `skip_cond` in 1: qualifier; a skip occurs only when `skip & skip_cond`
- `jmp` in 1: jump to `{jmp_cat, 0}`
- `jmp_cat` in CW: jump target category
- `call` in 1: push `ret_cat`, then jump to `{call_cat, 0}`
- `call_cat` in CW: subroutine category
- `ret_cat` in CW: category to resume at after return
- `ret` in 1: pop the stack and jump to `{popped, 0}`
- `int_req` in NINT: active-high interrupt requests, level-sensitive
- `int_mask` in NINT: 1 = channel masked
- `addr` out AW: registered ucode address
- `intvec` out NINT+1: one-hot vector of the current routine's source. Bit NINT = reset; bit i = channel i; all zero = opcode.
- `sp` out log2(DEPTH)+1: current stack occupancy
- `err` out 1: sticky stack error (see Configuration)

## Operation
- Next address is chosen each `cen` cycle while `halt=0`. Priority, highest first:
  1. `ret`
  2. `jmp`
  3. `call`
  4. `ni`
  5. sequential advance
- Lower-priority requests in the same cycle are ignored. A `call` ignored this way does not push.
- Sequential advance happens only when `stall=0`: `addr+1`, or `addr+2` when `skip & skip_cond`.
- Offset arithmetic wraps modulo AW bits. The sequencer does not protect routine boundaries.
- `ret`, `jmp`, `call` and `ni` take effect regardless of `stall`.
- `ni` arbitration:
  - Pending set is `int_req & ~int_mask`.
  - If the pending set is non-zero, the lowest set index i wins: `addr={INT_BASE+i,0}` and `intvec` = bit i.
  - Otherwise `addr={cat_in,0}` and `intvec=0`.
  - The stack is cleared to empty on `ni`.
- `intvec` changes only on `ni` or reset. It holds for the whole routine.
- Stack: `call` writes `ret_cat` at `sp` and increments `sp`. `ret` decrements `sp` and reads that entry.
- `halt` freezes `addr`, `sp`, the stack and `intvec`. Deasserting `halt` resumes from the frozen state.

## Timing
- Reset values:
  - `addr={RESET_CAT,0}`
  - `intvec` = bit NINT only
  - `sp=0`
  - `err=0`
  - stack contents don't-care
- `addr` is registered. A control input sampled at a `cen` edge is visible on `addr` one clock later.
- `cen=0` holds every register. Inputs are ignored.
- Interrupt requests are sampled only on `ni` cycles. A request that rises and falls between `ni` strobes is lost.
- Reset mid-routine or mid-call discards the stack immediately. Reset has priority over `halt`.
- A `call` with `sp=DEPTH`, or a `ret` with `sp=0`, is a stack error. Behaviour is given under Configuration.

## Configuration
- `JTKCPU_USEQ_CHK_EN` defined:
  - A stack error sets `err`. `err` is cleared only by reset.
  - While `err=1`, `addr`, `sp` and `intvec` freeze, as for `halt`.
  - The offending operation has no effect.
- `JTKCPU_USEQ_CHK_EN` undefined:
  - `err` is tied to 0.
  - The stack pointer wraps modulo DEPTH. Overflow overwrites the oldest entry. Underflow reads the wrapped entry.
  - `sp` reports the wrapped value.

## Test plan
- Reset release, `cen=1`, no controls, `stall=0` → `addr` 0,1,2,3; `intvec=4'b1000` (NINT=3). Hold `stall` → `addr` frozen.
- `skip=1, skip_cond=1` at `addr=5` → 7. With `skip_cond=0` → 6. With `stall=1` → stays 5.
- `call` (`call_cat=9`, `ret_cat=12`), then `call` (`call_cat=10`, `ret_cat=13`), then `ret`, `ret` → `addr` 0x240, 0x280, 0x340, 0x300; `sp` 1,2,1,0.
- `ni` with `int_req=3'b110`, `int_mask=3'b010` → `addr={INT_BASE+2,0}=0x0C0`, `intvec=4'b0100`. Next `ni` with `int_req=0`, `cat_in=7` → `addr=0x1C0`, `intvec=0`.
- Same cycle `ret`, `jmp` and `ni` with `sp=1`, top entry 5 → `addr=0x140`, `sp=0`, `intvec` unchanged.
- Five consecutive `call`s with DEPTH=4:
  - With `JTKCPU_USEQ_CHK_EN` → `err=1`, `addr` frozen at the fourth call's target, `sp=4`.
  - Without it → `err=0`, `sp` wraps to 1.
